// File: rtl/bolt_pkg.sv
// rtl/bolt_pkg.sv - shared bolt constants, owner encoding and arbiter state type
package bolt_pkg;

  // Default slot count, shared with the objects mux
  localparam int BOLT_MAX_DEFAULT = 4;

  // Slot owner encoding
  localparam logic OWN_PLR = 1'b0;
  localparam logic OWN_INV = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    LAUNCH = 1'b1
  } state_t;

endpackage

// File: rtl/bolt_slot_arbiter_if.sv
// rtl/bolt_slot_arbiter_if.sv - request/grant/slot-state bundle of the bolt slot arbiter
interface bolt_slot_arbiter_if #(
  parameter int BOLT_MAX = bolt_pkg::BOLT_MAX_DEFAULT,
  parameter int SW       = $clog2(BOLT_MAX)
) ();
  logic                startOfFrame;
  logic                plrFire;
  logic                invFire;
  logic [BOLT_MAX-1:0] boltDone;
  logic [BOLT_MAX-1:0] slotDrawReq;
  logic                plrAck;
  logic                invAck;
  logic [BOLT_MAX-1:0] launch;
  logic [SW-1:0]       grantSlot;
  logic [BOLT_MAX-1:0] slotActive;
  logic [BOLT_MAX-1:0] slotOwner;
  logic                btpReq;
  logic                btiReq;

  // Controller / bolt side: raises requests, consumes grants and slot state
  modport master (
    output startOfFrame, plrFire, invFire, boltDone, slotDrawReq,
    input  plrAck, invAck, launch, grantSlot, slotActive, slotOwner, btpReq, btiReq
  );

  // Arbiter side
  modport slave (
    input  startOfFrame, plrFire, invFire, boltDone, slotDrawReq,
    output plrAck, invAck, launch, grantSlot, slotActive, slotOwner, btpReq, btiReq
  );
endinterface

// File: rtl/bolt_slot_arbiter_free_slot_finder.sv
// rtl/bolt_slot_arbiter_free_slot_finder.sv - lowest-index-zero priority encoder
module free_slot_finder #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  busy_i,
  output logic          found_o,
  output logic [IW-1:0] index_o
);

  // Scan from the top down so the lowest free index is the last one written
  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy_i[i]) begin
        found_o = 1'b1;
        index_o = IW'(i);
      end
    end
  end

endmodule

// File: rtl/bolt_slot_arbiter.sv
// rtl/bolt_slot_arbiter.sv - shares bolt slots between player and invader fire requests
module bolt_slot_arbiter
  import bolt_pkg::*;
#(
  parameter int BOLT_MAX        = BOLT_MAX_DEFAULT,
  parameter int PLR_MAX         = 1,
  parameter int INV_MAX         = 3,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic               clk,
  input  logic               resetN,
  bolt_slot_arbiter_if.slave bus
);

  localparam int SW = $clog2(BOLT_MAX);
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

  state_t              state_q, state_d;
  logic                grant_owner_q, grant_owner_d;
  logic [SW-1:0]       grant_slot_q, grant_slot_d;
  logic                last_owner_q, last_owner_d;
  logic [CW-1:0]       cool_q, cool_d;
  logic [BOLT_MAX-1:0] active_q, active_d;
  logic [BOLT_MAX-1:0] owner_q, owner_d;

  logic                free_found;
  logic [SW-1:0]       free_idx;
  int                  plr_count;
  int                  inv_count;
  logic                plr_elig;
  logic                inv_elig;
  logic                launching;

  free_slot_finder #(.N(BOLT_MAX), .IW(SW)) u_free (
    .busy_i  (active_q),
    .found_o (free_found),
    .index_o (free_idx)
  );

  // Per-owner occupancy is derived from the slot state, never stored
  always_comb begin
    plr_count = 0;
    inv_count = 0;
    for (int i = 0; i < BOLT_MAX; i++) begin
      if (active_q[i]) begin
        if (owner_q[i] == OWN_INV) inv_count = inv_count + 1;
        else                       plr_count = plr_count + 1;
      end
    end
  end

  assign plr_elig  = bus.plrFire && (plr_count < PLR_MAX) && free_found;
  assign inv_elig  = bus.invFire && (inv_count < INV_MAX) && (cool_q == '0) && free_found;
  assign launching = (state_q == LAUNCH);

  // FSM next state: pick a winner in IDLE, spend exactly one cycle in LAUNCH
  always_comb begin
    state_d       = state_q;
    grant_owner_d = grant_owner_q;
    grant_slot_d  = grant_slot_q;
    case (state_q)
      IDLE: begin
        if (plr_elig && (!inv_elig || last_owner_q == OWN_INV)) begin
          state_d       = LAUNCH;
          grant_owner_d = OWN_PLR;
          grant_slot_d  = free_idx;
        end else if (inv_elig) begin
          state_d       = LAUNCH;
          grant_owner_d = OWN_INV;
          grant_slot_d  = free_idx;
        end
      end
      LAUNCH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slot, fairness and cooldown next state; a launch outranks a release or a decrement
  always_comb begin
    active_d     = active_q & ~bus.boltDone;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cool_d       = cool_q;
    if (bus.startOfFrame && cool_q != '0) cool_d = cool_q - CW'(1);
    if (launching) begin
      active_d[grant_slot_q] = 1'b1;
      owner_d[grant_slot_q]  = grant_owner_q;
      last_owner_d           = grant_owner_q;
      if (grant_owner_q == OWN_INV) cool_d = CW'(COOLDOWN_FRAMES);
    end
  end

  // State registers; reset in LAUNCH drops the pending grant
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE;
      grant_owner_q <= OWN_PLR;
      grant_slot_q  <= '0;
      last_owner_q  <= OWN_INV;
      cool_q        <= '0;
      active_q      <= '0;
      owner_q       <= '0;
    end else begin
      state_q       <= state_d;
      grant_owner_q <= grant_owner_d;
      grant_slot_q  <= grant_slot_d;
      last_owner_q  <= last_owner_d;
      cool_q        <= cool_d;
      active_q      <= active_d;
      owner_q       <= owner_d;
    end
  end

  // Grant outputs decode straight from registers, so they are glitch-free and one cycle long
  always_comb begin
    bus.plrAck    = launching && (grant_owner_q == OWN_PLR);
    bus.invAck    = launching && (grant_owner_q == OWN_INV);
    bus.launch    = launching ? (BOLT_MAX'(1) << grant_slot_q) : '0;
    bus.grantSlot = launching ? grant_slot_q : '0;
  end

  // Draw request fold adds no pipeline stage ahead of the objects mux
  always_comb begin
    bus.slotActive = active_q;
    bus.slotOwner  = owner_q;
    bus.btpReq     = |(active_q & ~owner_q & bus.slotDrawReq);
    bus.btiReq     = |(active_q &  owner_q & bus.slotDrawReq);
  end

endmodule

// File: tb/tb_bolt_slot_arbiter.sv
// tb/tb_bolt_slot_arbiter.sv - directed bench with slot-level reference model for bolt_slot_arbiter
module tb_bolt_slot_arbiter;
  import bolt_pkg::*;

  localparam int NB   = 4;
  localparam int PMAX = 1;
  localparam int IMAX = 3;
  localparam int COOL = 8;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  bit   chk_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  bolt_slot_arbiter_if #(.BOLT_MAX(NB)) bus ();

  bolt_slot_arbiter #(
    .BOLT_MAX(NB), .PLR_MAX(PMAX), .INV_MAX(IMAX), .COOLDOWN_FRAMES(COOL)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the slot pool as arrays, plus the grant that is due next cycle
  bit m_act[NB];
  bit m_own[NB];
  int m_cool;
  bit m_last;
  bit m_pend;
  bit m_pown;
  int m_pslot;
  int pc, ic, fr;
  bit pe, ie;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NB; i++) begin m_act[i] = 0; m_own[i] = 0; end
      m_cool = 0; m_last = 1; m_pend = 0; m_pown = 0; m_pslot = 0;
    end else if (m_pend) begin
      for (int i = 0; i < NB; i++)
        if (bus.boltDone[i] && i != m_pslot) m_act[i] = 0;
      m_act[m_pslot] = 1;
      m_own[m_pslot] = m_pown;
      m_last = m_pown;
      if (m_pown) m_cool = COOL;
      else if (bus.startOfFrame && m_cool > 0) m_cool = m_cool - 1;
      m_pend = 0;
    end else begin
      pc = 0; ic = 0; fr = -1;
      for (int i = 0; i < NB; i++) begin
        if (m_act[i]) begin
          if (m_own[i]) ic++; else pc++;
        end else if (fr < 0) fr = i;
      end
      pe = bus.plrFire && pc < PMAX && fr >= 0;
      ie = bus.invFire && ic < IMAX && m_cool == 0 && fr >= 0;
      if (pe && (!ie || m_last)) begin m_pend = 1; m_pown = 0; m_pslot = fr; end
      else if (ie)               begin m_pend = 1; m_pown = 1; m_pslot = fr; end
      for (int i = 0; i < NB; i++) if (bus.boltDone[i]) m_act[i] = 0;
      if (bus.startOfFrame && m_cool > 0) m_cool = m_cool - 1;
    end
  end

  // Every out-of-reset cycle: DUT outputs against the model
  always @(negedge clk) begin
    logic [NB-1:0] ea, eo, el;
    if (resetN && chk_en) begin
      for (int i = 0; i < NB; i++) begin
        ea[i] = m_act[i];
        eo[i] = m_own[i] & m_act[i];
        el[i] = m_pend && (m_pslot == i);
      end
      chk("m_plrAck",     bus.plrAck, m_pend && !m_pown);
      chk("m_invAck",     bus.invAck, m_pend && m_pown);
      chk("m_launch",     bus.launch, el);
      chk("m_grantSlot",  bus.grantSlot, m_pend ? m_pslot : 0);
      chk("m_slotActive", bus.slotActive, ea);
      chk("m_slotOwner",  bus.slotOwner & bus.slotActive, eo);
      chk("m_btpReq",     bus.btpReq, |(ea & ~eo & bus.slotDrawReq));
      chk("m_btiReq",     bus.btiReq, |(eo & bus.slotDrawReq));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof_pulses(input int n);
    for (int k = 0; k < n; k++) begin
      tick(); bus.startOfFrame = 1'b1;
      tick(); bus.startOfFrame = 1'b0;
    end
  endtask

  initial begin
    bus.startOfFrame = 0; bus.plrFire = 0; bus.invFire = 0;
    bus.boltDone = '0; bus.slotDrawReq = '0;
    resetN = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_active", bus.slotActive, 0);
    chk("rst_owner",  bus.slotOwner, 0);
    chk("rst_acks",   {bus.plrAck, bus.invAck}, 0);
    chk("rst_launch", bus.launch, 0);
    chk("rst_gslot",  bus.grantSlot, 0);
    tick(); resetN = 1; chk_en = 1;
    repeat (3) tick();

    // Single player request: ack one cycle after the sample, slot live the cycle after
    bus.plrFire = 1;
    @(negedge clk); chk("t1_no_ack_yet", bus.plrAck, 0);
    tick(); @(negedge clk);
    chk("t1_ack", bus.plrAck, 1);
    chk("t1_launch", bus.launch, 4'b0001);
    chk("t1_gslot", bus.grantSlot, 0);
    chk("t1_active_late", bus.slotActive, 4'b0000);
    tick(); @(negedge clk);
    chk("t1_active", bus.slotActive, 4'b0001);
    chk("t1_owner0", bus.slotOwner[0], 0);
    chk("t1_ack_gone", bus.plrAck, 0);

    // Player cap reached while still requesting, then release slot 0
    repeat (4) begin tick(); @(negedge clk); chk("t2_capped", bus.plrAck, 0); end
    tick(); bus.boltDone = 4'b0001;
    tick(); bus.boltDone = 4'b0000;
    @(negedge clk); chk("t2_freed", bus.slotActive, 0); chk("t2_no_ack", bus.plrAck, 0);
    tick(); @(negedge clk);
    chk("t2_reack", bus.plrAck, 1); chk("t2_launch", bus.launch, 4'b0001);
    tick(); bus.plrFire = 0;

    // Fresh reset so the tie sees the reset fairness state
    resetN = 0; repeat (2) tick(); resetN = 1; tick();
    bus.plrFire = 1; bus.invFire = 1;
    tick(); @(negedge clk);
    chk("t3_plr_first", bus.plrAck, 1); chk("t3_inv_wait", bus.invAck, 0);
    chk("t3_launch0", bus.launch, 4'b0001);
    tick(); bus.plrFire = 0;
    @(negedge clk); chk("t3_gap", {bus.plrAck, bus.invAck}, 0);
    tick(); @(negedge clk);
    chk("t3_inv_ack", bus.invAck, 1); chk("t3_gslot1", bus.grantSlot, 1);
    chk("t3_launch1", bus.launch, 4'b0010);

    // Invader cooldown: held request waits for 8 frame pulses
    for (int k = 0; k < COOL; k++) begin
      tick(); bus.startOfFrame = 1;
      tick(); bus.startOfFrame = 0;
      @(negedge clk); chk("t4_cooling", bus.invAck, 0);
    end
    tick(); @(negedge clk);
    chk("t4_ack", bus.invAck, 1); chk("t4_gslot2", bus.grantSlot, 2);
    chk("t4_launch2", bus.launch, 4'b0100);

    // Fill slot 3, then everything is exhausted
    sof_pulses(COOL);
    tick(); @(negedge clk);
    chk("t5_ack3", bus.invAck, 1); chk("t5_gslot3", bus.grantSlot, 3);
    bus.plrFire = 1;
    repeat (3) begin tick(); @(negedge clk); chk("t5_full", {bus.plrAck, bus.invAck}, 0); end
    sof_pulses(COOL);
    @(negedge clk); chk("t5_full_cool0", {bus.plrAck, bus.invAck}, 0);
    tick(); bus.boltDone = 4'b0100;
    @(negedge clk); chk("t5_still_full", bus.invAck, 0);
    tick(); bus.boltDone = 4'b0000;
    @(negedge clk); chk("t5_slot2_free", bus.slotActive, 4'b1011);
    tick(); @(negedge clk);
    chk("t5_reuse_ack", bus.invAck, 1); chk("t5_reuse_slot", bus.grantSlot, 2);
    chk("t5_plr_capped", bus.plrAck, 0);

    // Arrange slot 1 invader, slot 3 player, slot 2 free
    tick(); bus.plrFire = 0; bus.invFire = 0; bus.boltDone = 4'b1001;
    tick(); bus.boltDone = 4'b0000;
    sof_pulses(COOL);
    bus.invFire = 1;
    tick(); @(negedge clk); chk("t6_inv_slot0", bus.grantSlot, 0); chk("t6_inv_ack", bus.invAck, 1);
    tick(); bus.invFire = 0; bus.plrFire = 1;
    tick(); @(negedge clk); chk("t6_plr_slot3", bus.grantSlot, 3); chk("t6_plr_ack", bus.plrAck, 1);
    tick(); bus.plrFire = 0; bus.boltDone = 4'b0100;
    tick(); bus.boltDone = 4'b0000;
    tick(); bus.slotDrawReq = 4'b1010;
    @(negedge clk); chk("t6_btp", bus.btpReq, 1); chk("t6_bti", bus.btiReq, 1);
    tick(); bus.slotDrawReq = 4'b0100;
    @(negedge clk); chk("t6_idle_btp", bus.btpReq, 0); chk("t6_idle_bti", bus.btiReq, 0);
    tick(); bus.slotDrawReq = 4'b0001;
    @(negedge clk); chk("t6_s0_btp", bus.btpReq, 0); chk("t6_s0_bti", bus.btiReq, 1);
    tick(); bus.slotDrawReq = 4'b0000;

    // Reset during LAUNCH aborts the grant
    bus.boltDone = 4'b1000;
    tick(); bus.boltDone = 4'b0000; bus.plrFire = 1;
    tick(); #2 resetN = 0; bus.plrFire = 0;
    @(negedge clk); chk("t7_abort_ack", bus.plrAck, 0); chk("t7_abort_launch", bus.launch, 0);
    tick(); tick(); resetN = 1;
    repeat (3) begin
      tick(); @(negedge clk);
      chk("t7_no_ack", {bus.plrAck, bus.invAck}, 0);
      chk("t7_no_launch", bus.launch, 0);
      chk("t7_empty", bus.slotActive, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
